// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage of the 16-bit accumulator pipeline:
// op encodings from execute, FSM state encoding and default widths.
package cpu_pkg;

    localparam int MA_DW      = 16;
    localparam int MA_AW      = 16;
    localparam int MA_TIMEOUT = 64;

    // Operation requested by execute; 2'b11 is not a legal op.
    typedef enum logic [1:0] {
        MA_PASS    = 2'b00,
        MA_LOAD    = 2'b01,
        MA_STORE   = 2'b10,
        MA_ILLEGAL = 2'b11
    } ma_op_e;

    // MEM stage FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } ma_state_e;

endpackage

// File: rtl/ma_timeout_ctr.sv
// Counts memory-request cycles that pass without an acknowledge and flags
// expiry on the cycle the count sits at TIMEOUT-1 while still enabled.
module ma_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is only meaningful while counting; an ack disables counting,
    // so an ack on the final cycle naturally suppresses expiry.
    assign expire_o = enable_i && (count_q == LAST);

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: accepts one PASS/LOAD/STORE op at a time from execute, runs the
// memory transaction with an ack timeout, and hands results to writeback
// over a valid/ready handshake. Illegal ops and timeouts set a sticky error.
module memory_access
    import cpu_pkg::*;
#(
    parameter int DW      = MA_DW,
    parameter int AW      = MA_AW,
    parameter int TIMEOUT = MA_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_program,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [1:0]    ex_op,
    input  logic [AW-1:0] MAR,
    input  logic [DW-1:0] MBR,
    input  logic [DW-1:0] alu_result,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] data_out,
    output logic          ma_err
);

    ma_state_e     state_q;
    ma_op_e        op_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          wb_valid_q;
    logic [DW-1:0] data_out_q;
    logic          ma_err_q;

    logic          accept;
    logic          hold_done;
    ma_op_e        new_op;
    logic          tmo_clear;
    logic          tmo_enable;
    logic          tmo_expire;

    // A new op may enter when idle, or when the held result leaves this cycle.
    assign ex_ready  = !halt_program &&
                       ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && wb_ready));
    assign accept    = ex_valid && ex_ready;
    assign hold_done = (state_q == ST_HOLD) && wb_ready;
    assign new_op    = ma_op_e'(ex_op);

    // Count only REQ cycles without ack; restart from zero outside REQ.
    assign tmo_clear  = (state_q != ST_REQ);
    assign tmo_enable = (state_q == ST_REQ) && !mem_ack;

    ma_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmo_clear),
        .enable_i (tmo_enable),
        .expire_o (tmo_expire)
    );

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign data_out  = data_out_q;
    assign ma_err    = ma_err_q;

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= MA_PASS;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            data_out_q  <= '0;
            ma_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        op_q <= new_op;
                        case (new_op)
                            MA_PASS: begin
                                data_out_q <= alu_result;
                                wb_valid_q <= 1'b1;
                                state_q    <= ST_HOLD;
                            end
                            MA_LOAD, MA_STORE: begin
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= (new_op == MA_STORE);
                                mem_addr_q  <= MAR;
                                mem_wdata_q <= MBR;
                                wb_valid_q  <= 1'b0;
                                state_q     <= ST_REQ;
                            end
                            default: begin
                                // Illegal op is consumed with no side effect
                                // beyond flagging the error.
                                ma_err_q   <= 1'b1;
                                wb_valid_q <= 1'b0;
                                state_q    <= ST_IDLE;
                            end
                        endcase
                    end else if (hold_done) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (op_q == MA_LOAD) begin
                            data_out_q <= mem_rdata;
                            wb_valid_q <= 1'b1;
                            state_q    <= ST_HOLD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (tmo_expire) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        ma_err_q  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: a table of PASS/illegal vectors streamed
// back-to-back, then hand-written multi-cycle sequences for memory traffic,
// backpressure, timeout, halt and reset.
module tb_memory_access;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TMO = 8;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt_program;
    logic          ex_valid;
    logic          ex_ready;
    logic [1:0]    ex_op;
    logic [AW-1:0] MAR;
    logic [DW-1:0] MBR;
    logic [DW-1:0] alu_result;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] data_out;
    logic          ma_err;

    int n_cmp  = 0;
    int n_fail = 0;

    memory_access #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt_program (halt_program),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op        (ex_op),
        .MAR          (MAR),
        .MBR          (MBR),
        .alu_result   (alu_result),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .data_out     (data_out),
        .ma_err       (ma_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] alu;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".mem_req"},   32'(mem_req),   32'h0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'h0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'h0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, ".wb_valid"},  32'(wb_valid),  32'h0);
        chk({tag, ".data_out"},  32'(data_out),  32'h0);
        chk({tag, ".ma_err"},    32'(ma_err),    32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt_program = 1'b0; ex_valid = 1'b0; ex_op = OP_PASS;
        MAR = '0; MBR = '0; alu_result = '0; mem_rdata = '0; mem_ack = 1'b0;
        wb_ready = 1'b1;

        vecs[0] = '{OP_PASS, 16'h1234, 1'b1, 16'h1234, 1'b0};
        vecs[1] = '{OP_PASS, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[2] = '{OP_PASS, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
        vecs[3] = '{OP_PASS, 16'hA5A5, 1'b1, 16'hA5A5, 1'b0};
        vecs[4] = '{OP_ILL,  16'h5555, 1'b0, 16'hA5A5, 1'b1};

        // Reset state
        do_reset();
        check_all_zero("reset");
        chk("reset.ex_ready", 32'(ex_ready), 32'h1);
        $display("txn reset: outputs checked");

        // Table: back-to-back PASS stream, ending with an illegal op
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1'b1; ex_op = vecs[i].op; alu_result = vecs[i].alu; wb_ready = 1'b1;
            step();
            $display("txn vec%0d op=%0d alu=%h -> wb_valid=%0b data_out=%h ma_err=%0b",
                     i, vecs[i].op, vecs[i].alu, wb_valid, data_out, ma_err);
            chk($sformatf("vec%0d.wb_valid", i), 32'(wb_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d.ma_err", i),   32'(ma_err),   32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.ex_ready", i), 32'(ex_ready), 32'h1);
            chk($sformatf("vec%0d.mem_req", i),  32'(mem_req),  32'h0);
        end
        ex_valid = 1'b0;
        step();
        chk("illegal.sticky", 32'(ma_err), 32'h1);
        do_reset();
        chk("illegal.rst_clears", 32'(ma_err), 32'h0);

        // LOAD with ack on the third request cycle
        ex_valid = 1'b1; ex_op = OP_LOAD; MAR = 16'h0040;
        step();
        ex_valid = 1'b0;
        chk("load.req1", 32'(mem_req), 32'h1);
        chk("load.addr", 32'(mem_addr), 32'h0040);
        chk("load.we", 32'(mem_we), 32'h0);
        chk("load.ex_ready", 32'(ex_ready), 32'h0);
        step();
        chk("load.req2", 32'(mem_req), 32'h1);
        step();
        chk("load.req3", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("load.req_drop", 32'(mem_req), 32'h0);
        chk("load.wb_valid", 32'(wb_valid), 32'h1);
        chk("load.data_out", 32'(data_out), 32'hBEEF);
        step();
        chk("load.wb_done", 32'(wb_valid), 32'h0);
        $display("txn load 0040 -> data_out=%h", 16'hBEEF);

        // STORE: write data held until ack, no writeback
        ex_valid = 1'b1; ex_op = OP_STORE; MAR = 16'h0010; MBR = 16'h00AA;
        step();
        ex_valid = 1'b0; MBR = 16'h0000; MAR = 16'h0000;
        chk("store.req", 32'(mem_req), 32'h1);
        chk("store.we", 32'(mem_we), 32'h1);
        chk("store.addr", 32'(mem_addr), 32'h0010);
        chk("store.wdata1", 32'(mem_wdata), 32'h00AA);
        step();
        chk("store.wdata2", 32'(mem_wdata), 32'h00AA);
        chk("store.wb_valid_req", 32'(wb_valid), 32'h0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("store.req_drop", 32'(mem_req), 32'h0);
        chk("store.wb_valid", 32'(wb_valid), 32'h0);
        chk("store.ex_ready", 32'(ex_ready), 32'h1);
        step();
        chk("store.wb_valid_after", 32'(wb_valid), 32'h0);
        $display("txn store 0010 <= 00AA");

        // mem_ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        step();
        mem_ack = 1'b0;
        chk("stray_ack.wb_valid", 32'(wb_valid), 32'h0);
        chk("stray_ack.err", 32'(ma_err), 32'h0);

        // LOAD held under writeback backpressure, then back-to-back accept
        wb_ready = 1'b0;
        ex_valid = 1'b1; ex_op = OP_LOAD; MAR = 16'h0050;
        step();
        ex_valid = 1'b1; ex_op = OP_PASS; alu_result = 16'h2222;
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp%0d.wb_valid", i), 32'(wb_valid), 32'h1);
            chk($sformatf("bp%0d.data_out", i), 32'(data_out), 32'h1111);
            chk($sformatf("bp%0d.ex_ready", i), 32'(ex_ready), 32'h0);
            step();
        end
        wb_ready = 1'b1;
        #1;
        chk("bp.ex_ready_rise", 32'(ex_ready), 32'h1);
        step();
        ex_valid = 1'b0;
        chk("bp.b2b.wb_valid", 32'(wb_valid), 32'h1);
        chk("bp.b2b.data_out", 32'(data_out), 32'h2222);
        step();
        chk("bp.idle.wb_valid", 32'(wb_valid), 32'h0);
        $display("txn backpressure load 0050 then pass 2222");

        // Timeout: no ack for TMO request cycles
        ex_valid = 1'b1; ex_op = OP_LOAD; MAR = 16'h0060;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk($sformatf("tmo.req%0d", i), 32'(mem_req), 32'h1);
            chk($sformatf("tmo.err%0d", i), 32'(ma_err), 32'h0);
            step();
        end
        chk("tmo.req_drop", 32'(mem_req), 32'h0);
        chk("tmo.err_set", 32'(ma_err), 32'h1);
        chk("tmo.wb_valid", 32'(wb_valid), 32'h0);
        step();
        step();
        chk("tmo.err_sticky", 32'(ma_err), 32'h1);
        do_reset();
        chk("tmo.err_rst", 32'(ma_err), 32'h0);
        $display("txn load 0060 timed out");

        // Ack arriving on the expiry cycle wins
        ex_valid = 1'b1; ex_op = OP_LOAD; MAR = 16'h0070;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step();
        chk("tmo_ack.req_last", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 16'h3333;
        step();
        mem_ack = 1'b0;
        chk("tmo_ack.err", 32'(ma_err), 32'h0);
        chk("tmo_ack.wb_valid", 32'(wb_valid), 32'h1);
        chk("tmo_ack.data_out", 32'(data_out), 32'h3333);
        step();
        $display("txn load 0070 ack at expiry -> %h", 16'h3333);

        // halt_program during REQ: load and handshake still complete
        ex_valid = 1'b1; ex_op = OP_LOAD; MAR = 16'h0080;
        step();
        halt_program = 1'b1;
        ex_valid = 1'b1; ex_op = OP_PASS; alu_result = 16'h7777;
        #1;
        chk("halt.ex_ready_req", 32'(ex_ready), 32'h0);
        mem_ack = 1'b1; mem_rdata = 16'h4444;
        step();
        mem_ack = 1'b0;
        chk("halt.wb_valid", 32'(wb_valid), 32'h1);
        chk("halt.data_out", 32'(data_out), 32'h4444);
        chk("halt.ex_ready_hold", 32'(ex_ready), 32'h0);
        step();
        chk("halt.wb_done", 32'(wb_valid), 32'h0);
        chk("halt.ex_ready_idle", 32'(ex_ready), 32'h0);
        step();
        chk("halt.no_accept", 32'(wb_valid), 32'h0);
        chk("halt.err", 32'(ma_err), 32'h0);
        ex_valid = 1'b0; halt_program = 1'b0;
        $display("txn halted load 0080 -> %h", 16'h4444);

        // Reset in the middle of a store request
        ex_valid = 1'b1; ex_op = OP_STORE; MAR = 16'h0090; MBR = 16'h5A5A;
        step();
        ex_valid = 1'b0;
        chk("rst_mid.req_before", 32'(mem_req), 32'h1);
        rst = 1'b1;
        step();
        check_all_zero("rst_mid");
        rst = 1'b0;
        step();
        chk("rst_mid.no_retry", 32'(mem_req), 32'h0);
        $display("txn reset during store 0090");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
